// File: rtl/pl_mem_bridge_if.sv
`default_nettype none
// ============================================================================
// pl_mem_bridge_if : PS register port and PL command port of the mailbox bridge
// Revision 1.0
// ============================================================================
interface pl_mem_bridge_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic              ps_wr_en;
  logic              ps_rd_en;
  logic [ADDR_W-1:0] ps_addr;
  logic [DATA_W-1:0] ps_wdata;
  logic [DATA_W-1:0] ps_rdata;
  logic              ps_rvalid;
  logic              ps_irq;
  logic [1:0]        ps_status;
  logic [2:0]        cmd;
  logic [ADDR_W-1:0] address_pl;
  logic [DATA_W-1:0] data_pl;
  logic [DATA_W-1:0] data_in;
  logic              ready;
  logic              done_pl;
  logic [15:0]       collision_cnt;

  modport master (
    output ps_wr_en, ps_rd_en, ps_addr, ps_wdata, cmd, address_pl, data_pl, done_pl,
    input  ps_rdata, ps_rvalid, ps_irq, ps_status, data_in, ready, collision_cnt
  );

  modport slave (
    input  ps_wr_en, ps_rd_en, ps_addr, ps_wdata, cmd, address_pl, data_pl, done_pl,
    output ps_rdata, ps_rvalid, ps_irq, ps_status, data_in, ready, collision_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pl_mem_bridge.sv
`default_nettype none
// ============================================================================
// pl_mem_bridge : shared PS/PL mailbox memory with run-control sequencer;
// define PLMEM_COLLISION_CNT_EN to build the same-address collision counter.
// Revision 1.0
// ============================================================================
module pl_mem_bridge #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned INSTR_ADDR = 253,
  parameter int unsigned CTRL_ADDR  = 252
) (
  input  wire logic      clk,
  input  wire logic      rst,
  pl_mem_bridge_if.slave bus
);
  localparam logic [1:0]        ST_IDLE   = 2'd0;
  localparam logic [1:0]        ST_ARMED  = 2'd1;
  localparam logic [1:0]        ST_BUSY   = 2'd2;
  localparam logic [1:0]        ST_DONE   = 2'd3;
  localparam logic [2:0]        CMD_WRITE = 3'd2;
  localparam logic [2:0]        CMD_READ  = 3'd3;
  localparam logic [ADDR_W-1:0] INSTR_A   = ADDR_W'(INSTR_ADDR);
  localparam logic [ADDR_W-1:0] CTRL_A    = ADDR_W'(CTRL_ADDR);
  localparam int unsigned       DEPTH     = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic [DATA_W-1:0] ps_rdata_q, ps_rdata_d;
  logic              ps_rvalid_q, ps_rvalid_d;
  logic              ps_irq_q, ps_irq_d;
  logic              ready;
  logic              pl_wr, pl_rd, collide;

  assign pl_wr   = (bus.cmd == CMD_WRITE);
  assign pl_rd   = (bus.cmd == CMD_READ);
  assign collide = pl_wr && bus.ps_wr_en && (bus.address_pl == bus.ps_addr);

  // Storage is never reset; on a same-address double write the PL data lands.
  always_ff @(posedge clk) begin
    if (bus.ps_wr_en && !collide) mem[bus.ps_addr] <= bus.ps_wdata;
    if (pl_wr)                    mem[bus.address_pl] <= bus.data_pl;
  end

  always_comb begin
    data_in_d   = data_in_q;
    ps_rdata_d  = ps_rdata_q;
    ps_rvalid_d = bus.ps_rd_en;
    if (pl_rd)          data_in_d  = mem[bus.address_pl];
    if (bus.ps_rd_en)   ps_rdata_d = mem[bus.ps_addr];
  end

  // Next-state logic; a stale done_pl level from the last run keeps us in ARMED.
  always_comb begin
    state_d  = state_q;
    ps_irq_d = 1'b0;
    case (state_q)
      ST_IDLE:  if (bus.ps_wr_en && (bus.ps_addr == INSTR_A)) state_d = ST_ARMED;
      ST_ARMED: if (!bus.done_pl) state_d = ST_BUSY;
      ST_BUSY: begin
        if (bus.done_pl) begin
          state_d  = ST_DONE;
          ps_irq_d = 1'b1;
        end
      end
      ST_DONE:  if (bus.ps_wr_en && (bus.ps_addr == CTRL_A)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == ST_ARMED) || (state_q == ST_BUSY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      data_in_q   <= '0;
      ps_rdata_q  <= '0;
      ps_rvalid_q <= 1'b0;
      ps_irq_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_in_q   <= data_in_d;
      ps_rdata_q  <= ps_rdata_d;
      ps_rvalid_q <= ps_rvalid_d;
      ps_irq_q    <= ps_irq_d;
    end
  end

`ifdef PLMEM_COLLISION_CNT_EN
  logic [15:0] coll_cnt_q, coll_cnt_d;

  always_comb begin
    coll_cnt_d = coll_cnt_q;
    if (collide && (coll_cnt_q != 16'hFFFF)) coll_cnt_d = coll_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) coll_cnt_q <= '0;
    else     coll_cnt_q <= coll_cnt_d;
  end

  assign bus.collision_cnt = coll_cnt_q;
`else
  assign bus.collision_cnt = 16'd0;
`endif

  assign bus.data_in   = data_in_q;
  assign bus.ps_rdata  = ps_rdata_q;
  assign bus.ps_rvalid = ps_rvalid_q;
  assign bus.ps_irq    = ps_irq_q;
  assign bus.ps_status = state_q;
  assign bus.ready     = ready;

endmodule
`default_nettype wire

// File: tb/tb_pl_mem_bridge.sv
`default_nettype none
// ============================================================================
// tb_pl_mem_bridge : scenario tasks plus randomized traffic against a word-array model
// Revision 1.0
// ============================================================================
module tb_pl_mem_bridge;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
`ifdef PLMEM_COLLISION_CNT_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   exp_coll = 0;
  logic [31:0] model_mem [256];

  pl_mem_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  pl_mem_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INSTR_ADDR(253), .CTRL_ADDR(252)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] coll_exp();
    return COLL_EN ? 16'(exp_coll) : 16'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ps_wr_en = 1'b0; bus.ps_rd_en = 1'b0; bus.ps_addr = '0; bus.ps_wdata = '0;
    bus.cmd = 3'd4; bus.address_pl = '0; bus.data_pl = '0;
  endtask

  task automatic ps_write(input logic [7:0] a, input logic [31:0] d);
    bus.ps_wr_en = 1'b1; bus.ps_addr = a; bus.ps_wdata = d;
    tick();
    bus.ps_wr_en = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic ps_read(input logic [7:0] a, output logic [31:0] d, output logic v);
    bus.ps_rd_en = 1'b1; bus.ps_addr = a;
    tick();
    d = bus.ps_rdata; v = bus.ps_rvalid;
    bus.ps_rd_en = 1'b0;
  endtask

  task automatic pl_read(input logic [7:0] a, output logic [31:0] d);
    bus.cmd = 3'd3; bus.address_pl = a;
    tick();
    d = bus.data_in;
    bus.cmd = 3'd4;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.done_pl = 1'b0;
    rst = 1'b1;
    #2;
    total++; if (bus.data_in !== 32'h0) begin bad++; $display("FAIL reset_data_in got=%h want=0", bus.data_in); end
    total++; if (bus.ps_rdata !== 32'h0) begin bad++; $display("FAIL reset_ps_rdata got=%h want=0", bus.ps_rdata); end
    total++; if (bus.ps_rvalid !== 1'b0) begin bad++; $display("FAIL reset_ps_rvalid got=%b want=0", bus.ps_rvalid); end
    total++; if (bus.ps_irq !== 1'b0) begin bad++; $display("FAIL reset_ps_irq got=%b want=0", bus.ps_irq); end
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", bus.ready); end
    total++; if (bus.ps_status !== 2'd0) begin bad++; $display("FAIL reset_status got=%0d want=0", bus.ps_status); end
    total++; if (bus.collision_cnt !== 16'd0) begin bad++; $display("FAIL reset_coll got=%0d want=0", bus.collision_cnt); end
    tick(); tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    total++; if (bus.ps_status !== 2'd0) begin bad++; $display("FAIL post_reset_status got=%0d want=0", bus.ps_status); end
  endtask

  task automatic test_full_run();
    logic [31:0] d;
    logic        v;
    int          irq_pulses;
    ps_write(8'd255, 32'h4321_1234);
    ps_write(8'd254, 32'd8);
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL run_ready_before_arm got=%b want=0", bus.ready); end
    ps_write(8'd253, 32'd1);
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL run_ready_after_arm got=%b want=1", bus.ready); end
    total++; if (bus.ps_status !== 2'd1) begin bad++; $display("FAIL run_armed got=%0d want=1", bus.ps_status); end
    tick();
    total++; if (bus.ps_status !== 2'd2) begin bad++; $display("FAIL run_busy got=%0d want=2", bus.ps_status); end
    // read of 255 held for three sampled cycles
    bus.cmd = 3'd3; bus.address_pl = 8'd255;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (bus.data_in !== model_mem[255]) begin bad++; $display("FAIL run_hold_rd%0d got=%h want=%h", k, bus.data_in, model_mem[255]); end
    end
    bus.cmd = 3'd4;
    tick();
    total++; if (bus.data_in !== model_mem[255]) begin bad++; $display("FAIL run_data_in_holds got=%h want=%h", bus.data_in, model_mem[255]); end
    pl_read(8'd254, d);
    total++; if (d !== 32'd8) begin bad++; $display("FAIL run_rd_bias got=%h want=8", d); end
    pl_read(8'd253, d);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL run_rd_instr got=%h want=1", d); end
    bus.cmd = 3'd2; bus.address_pl = 8'd1; bus.data_pl = 32'd37;
    tick();
    model_mem[1] = 32'd37;
    pl_read(8'd1, d);
    total++; if (d !== 32'd37) begin bad++; $display("FAIL run_wr_then_rd got=%h want=37", d); end
    bus.done_pl = 1'b1;
    tick();
    total++; if (bus.ps_status !== 2'd3) begin bad++; $display("FAIL run_done got=%0d want=3", bus.ps_status); end
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL run_done_ready got=%b want=0", bus.ready); end
    irq_pulses = (bus.ps_irq === 1'b1) ? 1 : 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.ps_irq === 1'b1) irq_pulses++;
    end
    total++; if (irq_pulses != 1) begin bad++; $display("FAIL run_irq_pulses got=%0d want=1", irq_pulses); end
    ps_read(8'd1, d, v);
    total++; if (v !== 1'b1 || d !== 32'd37) begin bad++; $display("FAIL run_ps_rd1 got=%h/%b want=37/1", d, v); end
    tick();
    total++; if (bus.ps_rvalid !== 1'b0) begin bad++; $display("FAIL run_rvalid_pulse got=%b want=0", bus.ps_rvalid); end
  endtask

  task automatic test_clear();
    ps_write(8'd252, 32'h0000_00C1);
    total++; if (bus.ps_status !== 2'd0) begin bad++; $display("FAIL clear_status got=%0d want=0", bus.ps_status); end
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL clear_ready got=%b want=0", bus.ready); end
    ps_write(8'd253, 32'd2);
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL clear_rearm_ready got=%b want=1", bus.ready); end
  endtask

  task automatic test_stale_done();
    // done_pl is still high from the previous run
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (bus.ps_status !== 2'd1 || bus.ps_irq !== 1'b0) begin bad++; $display("FAIL stale_hold%0d got=%0d/%b want=1/0", k, bus.ps_status, bus.ps_irq); end
    end
    bus.done_pl = 1'b0;
    tick();
    total++; if (bus.ps_status !== 2'd2 || bus.ps_irq !== 1'b0) begin bad++; $display("FAIL stale_busy got=%0d/%b want=2/0", bus.ps_status, bus.ps_irq); end
    bus.done_pl = 1'b1;
    tick();
    total++; if (bus.ps_status !== 2'd3 || bus.ps_irq !== 1'b1) begin bad++; $display("FAIL stale_done got=%0d/%b want=3/1", bus.ps_status, bus.ps_irq); end
    tick();
    total++; if (bus.ps_irq !== 1'b0) begin bad++; $display("FAIL stale_irq_once got=%b want=0", bus.ps_irq); end
    bus.done_pl = 1'b0;
    ps_write(8'd252, 32'd0);
    total++; if (bus.ps_status !== 2'd0) begin bad++; $display("FAIL stale_clear got=%0d want=0", bus.ps_status); end
  endtask

  task automatic test_spurious_arm();
    logic [31:0] d;
    logic        v;
    ps_write(8'd253, 32'd3);
    tick();
    total++; if (bus.ps_status !== 2'd2) begin bad++; $display("FAIL spur_busy got=%0d want=2", bus.ps_status); end
    ps_write(8'd253, 32'hDEAD_BEEF);
    total++; if (bus.ps_status !== 2'd2 || bus.ps_irq !== 1'b0) begin bad++; $display("FAIL spur_state got=%0d/%b want=2/0", bus.ps_status, bus.ps_irq); end
    ps_read(8'd253, d, v);
    total++; if (d !== 32'hDEAD_BEEF || v !== 1'b1) begin bad++; $display("FAIL spur_mem got=%h want=deadbeef", d); end
    total++; if (bus.ps_status !== 2'd2 || bus.ps_irq !== 1'b0) begin bad++; $display("FAIL spur_state2 got=%0d/%b want=2/0", bus.ps_status, bus.ps_irq); end
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] d;
    logic        v;
    pl_read(8'd255, d);
    total++; if (d !== 32'h4321_1234) begin bad++; $display("FAIL rstmid_pre_rd got=%h want=43211234", d); end
    #3;
    rst = 1'b1;
    exp_coll = 0;
    #1;
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready got=%b want=0", bus.ready); end
    total++; if (bus.data_in !== 32'h0) begin bad++; $display("FAIL rstmid_data_in got=%h want=0", bus.data_in); end
    total++; if (bus.ps_status !== 2'd0) begin bad++; $display("FAIL rstmid_status got=%0d want=0", bus.ps_status); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    ps_read(8'd255, d, v);
    total++; if (d !== 32'h4321_1234 || v !== 1'b1) begin bad++; $display("FAIL rstmid_mem got=%h want=43211234", d); end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    logic        v;
    bus.ps_wr_en = 1'b1; bus.ps_addr = 8'd5; bus.ps_wdata = 32'hAAAA_AAAA;
    bus.cmd = 3'd2; bus.address_pl = 8'd5; bus.data_pl = 32'h5555_5555;
    tick();
    idle_inputs();
    model_mem[5] = 32'h5555_5555;
    exp_coll++;
    total++; if (bus.collision_cnt !== coll_exp()) begin bad++; $display("FAIL coll_cnt got=%0d want=%0d", bus.collision_cnt, coll_exp()); end
    ps_read(8'd5, d, v);
    total++; if (d !== 32'h5555_5555) begin bad++; $display("FAIL coll_pl_wins got=%h want=55555555", d); end
    // distinct addresses in the same cycle both land and are not a collision
    bus.ps_wr_en = 1'b1; bus.ps_addr = 8'd6; bus.ps_wdata = 32'h0000_0066;
    bus.cmd = 3'd2; bus.address_pl = 8'd7; bus.data_pl = 32'h0000_0077;
    tick();
    idle_inputs();
    model_mem[6] = 32'h66; model_mem[7] = 32'h77;
    ps_read(8'd6, d, v);
    total++; if (d !== 32'h66) begin bad++; $display("FAIL coll_distinct_ps got=%h want=66", d); end
    total++; if (bus.collision_cnt !== coll_exp()) begin bad++; $display("FAIL coll_distinct_cnt got=%0d want=%0d", bus.collision_cnt, coll_exp()); end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [31:0] exp_data_in, exp_rdata;
    logic        exp_rvalid, pw, pr;
    logic [7:0]  pa, la;
    logic [2:0]  c;
    logic [31:0] wd, ld;
    for (int a = 0; a < 32; a++) ps_write(8'(a), $urandom());
    pl_read(8'd0, d);
    total++; if (d !== model_mem[0]) begin bad++; $display("FAIL rnd_init got=%h want=%h", d, model_mem[0]); end
    exp_data_in = model_mem[0];
    for (int i = 0; i < 300; i++) begin
      pw = 1'($urandom_range(0, 1));
      pr = 1'($urandom_range(0, 1));
      pa = 8'($urandom_range(0, 31));
      la = ($urandom_range(0, 3) == 0) ? pa : 8'($urandom_range(0, 31));
      c  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(2, 3));
      wd = $urandom();
      ld = $urandom();
      bus.ps_wr_en = pw; bus.ps_rd_en = pr; bus.ps_addr = pa; bus.ps_wdata = wd;
      bus.cmd = c; bus.address_pl = la; bus.data_pl = ld;
      exp_rvalid = pr;
      exp_rdata  = model_mem[pa];
      if (c == 3'd3) exp_data_in = model_mem[la];
      if (pw) model_mem[pa] = wd;
      if (c == 3'd2) model_mem[la] = ld;
      if (pw && c == 3'd2 && pa == la && exp_coll < 65535) exp_coll++;
      tick();
      total++; if (bus.data_in !== exp_data_in) begin bad++; $display("FAIL rnd_data_in[%0d] got=%h want=%h", i, bus.data_in, exp_data_in); end
      total++; if (bus.ps_rvalid !== exp_rvalid) begin bad++; $display("FAIL rnd_rvalid[%0d] got=%b want=%b", i, bus.ps_rvalid, exp_rvalid); end
      if (exp_rvalid) begin
        total++; if (bus.ps_rdata !== exp_rdata) begin bad++; $display("FAIL rnd_rdata[%0d] got=%h want=%h", i, bus.ps_rdata, exp_rdata); end
      end
      total++; if (bus.collision_cnt !== coll_exp()) begin bad++; $display("FAIL rnd_coll[%0d] got=%0d want=%0d", i, bus.collision_cnt, coll_exp()); end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_clear();
    test_stale_done();
    test_spurious_arm();
    test_reset_mid_busy();
    test_collision();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
